// File: rtl/ddr3_cmd_arbiter.sv
// Round-robin command arbiter for the MIG app command port.
// Read tags are queued in order so each read beat finds its channel.
module ddr3_cmd_arbiter #(
  parameter int NUM_CH    = 4,
  parameter int ADDR_W    = 27,
  parameter int TAG_DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [NUM_CH-1:0]        ch_req,
  input  logic [NUM_CH-1:0]        ch_wr,
  input  logic [NUM_CH*ADDR_W-1:0] ch_addr,
  output logic [NUM_CH-1:0]        ch_ack,
  input  logic                     wr_enable,
  output logic [ADDR_W-1:0]        app_addr,
  output logic [2:0]               app_cmd,
  output logic                     app_en,
  input  logic                     app_rdy,
  input  logic                     app_rd_data_valid,
  output logic [NUM_CH-1:0]        rd_valid_ch,
  output logic                     rd_tag_full,
  output logic                     rd_underflow_err
);

  localparam int IDW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int PW  = (TAG_DEPTH > 1) ? $clog2(TAG_DEPTH) : 1;
  localparam int CW  = PW + 1;

  localparam logic [2:0] CMD_WR = 3'b000;
  localparam logic [2:0] CMD_RD = 3'b001;

  localparam logic [CW-1:0] CNT_MAX  = CW'(TAG_DEPTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(TAG_DEPTH - 1);

  logic [IDW-1:0]    ptr;
  logic [IDW-1:0]    reg_ch;
  logic [IDW-1:0]    gnt;
  logic [IDW-1:0]    gnt_next;
  logic              found;
  logic [NUM_CH-1:0] elig;
  logic [ADDR_W-1:0] gnt_addr;

  logic              free;
  logic              accept;
  logic              pend_rd;
  logic              rd_room;

  logic [IDW-1:0]    tag_mem [TAG_DEPTH];
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic [CW-1:0]     tag_count;
  logic              tag_empty;
  logic              push;
  logic              pop;
  logic [IDW-1:0]    head;

  assign accept  = app_en & app_rdy;
  assign free    = ~app_en | app_rdy;
  // A read sitting in the register, even one being accepted now,
  // is not in tag_count yet, so it still reserves a tag slot.
  assign pend_rd = app_en && (app_cmd == CMD_RD);
  assign rd_room = (tag_count < CNT_MAX) &&
                   !(pend_rd && (tag_count == CNT_LAST));

  assign tag_empty = (tag_count == '0);
  assign push      = accept && (app_cmd == CMD_RD);
  assign pop       = app_rd_data_valid && !tag_empty;
  assign head      = tag_mem[rd_ptr];

  assign rd_tag_full = (tag_count == CNT_MAX);
  assign rd_valid_ch = pop ? (NUM_CH'(1) << head) : '0;

  // Per-channel eligibility: writes need wr_enable, reads need a tag.
  always_comb begin
    elig = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (ch_req[i]) begin
        elig[i] = ch_wr[i] ? wr_enable : rd_room;
      end
    end
  end

  // Round-robin scan starting at ptr; first eligible channel wins.
  always_comb begin
    int idx;
    idx   = 0;
    found = 1'b0;
    gnt   = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      idx = int'(ptr) + k;
      if (idx >= NUM_CH) begin
        idx = idx - NUM_CH;
      end
      if (!found && elig[idx]) begin
        found = 1'b1;
        gnt   = IDW'(idx);
      end
    end
  end

  // Address of the winning channel and the pointer after it.
  always_comb begin
    gnt_addr = ch_addr[int'(gnt)*ADDR_W +: ADDR_W];
    if (int'(gnt) == NUM_CH - 1) begin
      gnt_next = '0;
    end else begin
      gnt_next = gnt + 1'b1;
    end
  end

  // Single-entry command register; reloads whenever it is free.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      app_en   <= 1'b0;
      app_cmd  <= CMD_WR;
      app_addr <= '0;
      ch_ack   <= '0;
      reg_ch   <= '0;
      ptr      <= '0;
    end else if (free) begin
      if (found) begin
        app_en   <= 1'b1;
        app_addr <= gnt_addr;
        app_cmd  <= ch_wr[gnt] ? CMD_WR : CMD_RD;
        reg_ch   <= gnt;
        ch_ack   <= NUM_CH'(1) << gnt;
        ptr      <= gnt_next;
      end else begin
        app_en   <= 1'b0;
        ch_ack   <= '0;
      end
    end else begin
      ch_ack <= '0;
    end
  end

  // Tag storage; contents need no reset, only the pointers do.
  always_ff @(posedge clk) begin
    if (push) begin
      tag_mem[wr_ptr] <= reg_ch;
    end
  end

  // Tag FIFO pointers and occupancy.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      tag_count <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      unique case ({push, pop})
        2'b10:   tag_count <= tag_count + 1'b1;
        2'b01:   tag_count <= tag_count - 1'b1;
        default: tag_count <= tag_count;
      endcase
    end
  end

  // Sticky flag for a read beat with no outstanding tag.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_underflow_err <= 1'b0;
    end else if (app_rd_data_valid && tag_empty) begin
      rd_underflow_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_ddr3_cmd_arbiter.sv
// Directed bench for ddr3_cmd_arbiter.
// Expected grants and tag order are worked out by hand per step.
module tb_ddr3_cmd_arbiter;

  localparam int NC = 4;
  localparam int AW = 27;
  localparam int TD = 16;

  logic             clk = 1'b0;
  logic             reset_n;
  logic [NC-1:0]    ch_req;
  logic [NC-1:0]    ch_wr;
  logic [NC*AW-1:0] ch_addr;
  logic [NC-1:0]    ch_ack;
  logic             wr_enable;
  logic [AW-1:0]    app_addr;
  logic [2:0]       app_cmd;
  logic             app_en;
  logic             app_rdy;
  logic             app_rd_data_valid;
  logic [NC-1:0]    rd_valid_ch;
  logic             rd_tag_full;
  logic             rd_underflow_err;

  logic [AW-1:0]    a [NC];
  int               checks = 0;
  int               errors = 0;
  int               acks;

  ddr3_cmd_arbiter #(
    .NUM_CH   (NC),
    .ADDR_W   (AW),
    .TAG_DEPTH(TD)
  ) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .ch_req           (ch_req),
    .ch_wr            (ch_wr),
    .ch_addr          (ch_addr),
    .ch_ack           (ch_ack),
    .wr_enable        (wr_enable),
    .app_addr         (app_addr),
    .app_cmd          (app_cmd),
    .app_en           (app_en),
    .app_rdy          (app_rdy),
    .app_rd_data_valid(app_rd_data_valid),
    .rd_valid_ch      (rd_valid_ch),
    .rd_tag_full      (rd_tag_full),
    .rd_underflow_err (rd_underflow_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input string tag, input logic [NC-1:0] exp);
    app_rd_data_valid = 1'b1;
    #1;
    chk(tag, 64'(rd_valid_ch), 64'(exp));
    step();
    app_rd_data_valid = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < NC; i++) begin
      a[i] = AW'(32'h0123450 + i * 32'h1111);
    end
    ch_addr           = {a[3], a[2], a[1], a[0]};
    reset_n           = 1'b0;
    ch_req            = '0;
    ch_wr             = '0;
    wr_enable         = 1'b1;
    app_rdy           = 1'b1;
    app_rd_data_valid = 1'b0;
    #3;
    chk("rst_en", 64'(app_en), 64'd0);
    chk("rst_cmd", 64'(app_cmd), 64'd0);
    chk("rst_addr", 64'(app_addr), 64'd0);
    chk("rst_ack", 64'(ch_ack), 64'd0);
    chk("rst_full", 64'(rd_tag_full), 64'd0);
    chk("rst_err", 64'(rd_underflow_err), 64'd0);
    #10;
    reset_n = 1'b1;

    // 1: four readers, round robin 0,1,2,3,0
    ch_req = 4'b1111;
    step();
    for (int k = 0; k < 5; k++) begin
      chk("t1_ack", 64'(ch_ack), 64'(4'b0001 << (k % 4)));
      chk("t1_en", 64'(app_en), 64'd1);
      chk("t1_cmd", 64'(app_cmd), 64'd1);
      chk("t1_addr", 64'(app_addr), 64'(a[k % 4]));
      if (k < 4) step();
    end
    ch_req = '0;
    step();
    chk("t1_idle", 64'(app_en), 64'd0);
    beat("t1_rd0", 4'b0001);
    beat("t1_rd1", 4'b0010);
    beat("t1_rd2", 4'b0100);
    beat("t1_rd3", 4'b1000);
    beat("t1_rd4", 4'b0001);

    // 2: ch1 write blocked until wr_enable, ch2 read goes first
    wr_enable = 1'b0;
    ch_req    = 4'b0110;
    ch_wr     = 4'b0010;
    step();
    chk("t2_ack2", 64'(ch_ack), 64'b0100);
    chk("t2_cmd2", 64'(app_cmd), 64'd1);
    ch_req = 4'b0010;
    step();
    chk("t2_blk", 64'(app_en), 64'd0);
    chk("t2_blk_ack", 64'(ch_ack), 64'd0);
    wr_enable = 1'b1;
    step();
    chk("t2_ack1", 64'(ch_ack), 64'b0010);
    chk("t2_cmd1", 64'(app_cmd), 64'd0);
    chk("t2_addr1", 64'(app_addr), 64'(a[1]));
    ch_req = '0;
    ch_wr  = '0;
    step();
    chk("t2_idle", 64'(app_en), 64'd0);
    beat("t2_rd", 4'b0100);

    // 3: hold while app_rdy low, next grant the cycle it rises
    app_rdy = 1'b0;
    ch_req  = 4'b0001;
    step();
    chk("t3_ack0", 64'(ch_ack), 64'b0001);
    ch_req = 4'b0010;
    for (int k = 0; k < 5; k++) begin
      step();
      chk("t3_en", 64'(app_en), 64'd1);
      chk("t3_addr", 64'(app_addr), 64'(a[0]));
      chk("t3_cmd", 64'(app_cmd), 64'd1);
      chk("t3_ack", 64'(ch_ack), 64'd0);
    end
    app_rdy = 1'b1;
    step();
    chk("t3_ack1", 64'(ch_ack), 64'b0010);
    chk("t3_addr1", 64'(app_addr), 64'(a[1]));
    ch_req = '0;
    step();
    chk("t3_idle", 64'(app_en), 64'd0);
    beat("t3_rd0", 4'b0001);
    beat("t3_rd1", 4'b0010);

    // 4: tag limit of 16 reads; writes still pass
    acks   = 0;
    ch_req = 4'b0001;
    for (int k = 0; k < 25; k++) begin
      step();
      if (ch_ack[0]) acks++;
    end
    chk("t4_reads", 64'(acks), 64'd16);
    chk("t4_full", 64'(rd_tag_full), 64'd1);
    ch_req = 4'b1001;
    ch_wr  = 4'b1000;
    step();
    chk("t4_wr_ack", 64'(ch_ack), 64'b1000);
    chk("t4_wr_cmd", 64'(app_cmd), 64'd0);
    ch_req = 4'b0001;
    ch_wr  = '0;
    step();
    chk("t4_rd_blk", 64'(ch_ack), 64'd0);
    beat("t4_pop", 4'b0001);
    step();
    chk("t4_rd_ok", 64'(ch_ack), 64'b0001);
    ch_req = '0;
    step();
    chk("t4_full2", 64'(rd_tag_full), 64'd1);
    for (int k = 0; k < TD; k++) begin
      beat("t4_drain", 4'b0001);
    end
    chk("t4_empty", 64'(rd_tag_full), 64'd0);

    // 5: ch3, ch0, ch3 reads, then a push coinciding with a pop
    ch_req = 4'b1000;
    step();
    chk("t5_a", 64'(ch_ack), 64'b1000);
    ch_req = 4'b0001;
    step();
    chk("t5_b", 64'(ch_ack), 64'b0001);
    ch_req = 4'b1000;
    step();
    chk("t5_c", 64'(ch_ack), 64'b1000);
    ch_req = '0;
    step();
    ch_req = 4'b0010;
    beat("t5_rd0", 4'b1000);
    chk("t5_ack1", 64'(ch_ack), 64'b0010);
    ch_req = '0;
    beat("t5_rd1", 4'b0001);
    beat("t5_rd2", 4'b1000);
    beat("t5_rd3", 4'b0010);

    // 6: underflow, then async reset with a command held
    app_rd_data_valid = 1'b1;
    #1;
    chk("t6_uf_vld", 64'(rd_valid_ch), 64'd0);
    step();
    chk("t6_err", 64'(rd_underflow_err), 64'd1);
    app_rd_data_valid = 1'b0;
    step();
    chk("t6_err_hold", 64'(rd_underflow_err), 64'd1);
    app_rdy = 1'b0;
    ch_req  = 4'b0100;
    step();
    chk("t6_load", 64'(app_en), 64'd1);
    chk("t6_ack2", 64'(ch_ack), 64'b0100);
    ch_req = '0;
    #2;
    reset_n = 1'b0;
    #1;
    chk("t6_rst_en", 64'(app_en), 64'd0);
    chk("t6_rst_err", 64'(rd_underflow_err), 64'd0);
    chk("t6_rst_ack", 64'(ch_ack), 64'd0);
    chk("t6_rst_addr", 64'(app_addr), 64'd0);
    #2;
    reset_n = 1'b1;
    app_rdy = 1'b1;
    ch_req  = 4'b1111;
    step();
    chk("t6_ptr0", 64'(ch_ack), 64'b0001);
    ch_req = '0;
    step();

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/ddr3_cmd_arbiter.md
Name: ddr3_cmd_arbiter

Overview:
- Parametrised successor to the fixed two-requester DDR3 address/command control.
- Arbitrates NUM_CH requesters (any mix of read/write) onto the MIG app command port using fair round-robin, gated by acquisition write enable.
- Tracks outstanding reads in an in-order tag FIFO so each MIG read beat is steered back to the channel that issued it.
- Sits between the per-channel wr/rd controllers and the MIG user interface, in the ddr3_domain_clk domain. Write data (app_wdf_*) stays with the channel controllers.

Parameters:
- NUM_CH, 4, number of requesting channels (>=2).
- ADDR_W, 27, app_addr width.
- TAG_DEPTH, 16, max outstanding reads accepted by MIG but not yet returned (power of 2).

Ports:
- clk  in  1  ddr3_domain_clk (MIG ui_clk).
- reset_n  in  1  asynchronous, active-low reset.
- ch_req  in  NUM_CH  per-channel command request, held until ch_ack.
- ch_wr  in  NUM_CH  1=write, 0=read; valid with ch_req.
- ch_addr  in  NUM_CH*ADDR_W  per-channel address; channel i at [i*ADDR_W +: ADDR_W].
- ch_ack  out  NUM_CH  one-cycle pulse; request captured into command register.
- wr_enable  in  1  writes eligible only when 1 (acq_enabled, already synchronised).
- app_addr  out  ADDR_W  MIG address.
- app_cmd  out  3  3'b000 write, 3'b001 read.
- app_en  out  1  MIG command valid.
- app_rdy  in  1  MIG accepts command when app_en&app_rdy.
- app_rd_data_valid  in  1  MIG read beat valid.
- rd_valid_ch  out  NUM_CH  one-hot owner of current read beat, combinational, same cycle as app_rd_data_valid.
- rd_tag_full  out  1  outstanding-read limit reached.
- rd_underflow_err  out  1  sticky; read beat arrived with tag FIFO empty.

Behaviour:
- Reset (async, reset_n=0):
  - app_en=0, app_cmd=0, app_addr=0, ch_ack=0.
  - Priority pointer=0, tag FIFO empty, rd_tag_full=0, rd_underflow_err=0.
- Command register, single entry:
  - The register is free when app_en=0, or when app_en&app_rdy this cycle (back-to-back issue, one command per cycle sustained).
- Eligibility of channel i:
  - Requires ch_req[i].
  - Writes additionally require wr_enable=1.
  - Reads additionally require (tag_count + read_pending_in_reg) < TAG_DEPTH. read_pending_in_reg is 1 if the register holds an unaccepted read.
- Grant:
  - When the register is free and any channel is eligible, grant the first eligible channel scanning ptr, ptr+1, ... mod NUM_CH.
  - Register loads app_addr=ch_addr[g], app_cmd from ch_wr[g], app_en=1. ch_ack[g]=1 for exactly that cycle; ptr <= (g+1) mod NUM_CH.
  - If the register is free and none is eligible: app_en <= 0, ptr unchanged.
  - ch_ack is registered and asserts the cycle the command appears on app_en.
- Hold: while app_en=1 and app_rdy=0, app_addr/app_cmd/app_en are held stable and no new grant occurs.
- wr_enable falling: a write already in the register still issues. Only new grants are blocked.
- Tag FIFO, depth TAG_DEPTH, width clog2(NUM_CH):
  - Push the granted channel id when app_en&app_rdy&app_cmd==001.
  - Pop on app_rd_data_valid. rd_valid_ch = onehot(head) & {NUM_CH{app_rd_data_valid}}.
  - Simultaneous push and pop: count unchanged; the head is popped before the new entry becomes visible.
  - Pointer wrap is modulo TAG_DEPTH.
  - rd_tag_full = (tag_count == TAG_DEPTH).
- Underflow: app_rd_data_valid with FIFO empty gives rd_valid_ch=0, no pop, rd_underflow_err set. It clears only on reset.
- Ordering: the MIG returns reads in order (strict mode), so one beat per command (BL8, 128-bit) maps 1:1 to a tag.
- Reset mid-operation: everything returns to reset values immediately. A pending command is dropped and ch_ack is not pulsed.

Test Plan:
1. All 4 channels reads, req held, app_rdy=1 → grants 0,1,2,3,0 on consecutive cycles, one ch_ack per cycle. app_cmd=001, app_addr matches each channel.
2. ch1 write + ch2 read, wr_enable=0 → only ch2 granted; ch1 granted the cycle after wr_enable rises; app_cmd=000, app_addr=ch1 address.
3. app_rdy=0 for 5 cycles with a command loaded → app_en/app_addr/app_cmd stable, no ch_ack. On app_rdy=1 the next grant comes the same cycle.
4. TAG_DEPTH=16: 16 reads accepted with no read data → rd_tag_full=1 and further reads not granted while writes still are. One app_rd_data_valid lets the next read grant.
5. Reads issued by ch3,ch0,ch3 then 3 valid beats → rd_valid_ch = 1000, 0001, 1000. A push coinciding with the pop leaves count correct.
6. app_rd_data_valid with empty FIFO → rd_valid_ch=0, rd_underflow_err=1 and held. reset_n pulse mid-hold → app_en=0, err=0, ptr=0 asynchronously.
